// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and types for the 7-segment scan display
package display_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] digit_addr_t;

  // Active-high segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD to 7-segment decoder, non-BCD codes dark
module bcd_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] segments
);

  // Map each BCD digit to its segment pattern; codes 10..15 show nothing
  always_comb begin
    segments = SEG_OFF;
    case (bcd)
      4'd0:    segments = SEG_0;
      4'd1:    segments = SEG_1;
      4'd2:    segments = SEG_2;
      4'd3:    segments = SEG_3;
      4'd4:    segments = SEG_4;
      4'd5:    segments = SEG_5;
      4'd6:    segments = SEG_6;
      4'd7:    segments = SEG_7;
      4'd8:    segments = SEG_8;
      4'd9:    segments = SEG_9;
      default: segments = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - 4-digit multiplexed 7-segment scan driver with blanking
module display_scan_controller
  import display_pkg::*;
#(
  parameter int PRESCALE     = 4096,
  parameter int BLANK_CYCLES = 64
) (
  input  logic       clk_in,
  input  logic       reset_n_in,
  input  logic       enable,
  input  logic       blank_leading_zero,
  input  logic [3:0] dp_mask,
  input  logic [3:0] digit_data,
  output logic [1:0] mux_address,
  output logic [6:0] segment_out,
  output logic       dp_out,
  output logic [3:0] digit_enable
);

  localparam int CW = $clog2(PRESCALE);

  logic [CW-1:0] slot_count;
  logic [CW-1:0] slot_count_next;
  digit_addr_t   addr;
  logic          leading;
  logic          wrap;
  logic          latch;
  logic          suppress;
  logic [6:0]    decoded;

  bcd_to_7seg u_decode (
    .bcd      (digit_data),
    .segments (decoded)
  );

  // Slot timing and leading-zero decision for the digit currently being latched
  always_comb begin
    wrap            = (slot_count == CW'(PRESCALE - 1));
    latch           = (slot_count == CW'(BLANK_CYCLES - 1));
    slot_count_next = wrap ? '0 : slot_count + 1'b1;
    suppress        = blank_leading_zero && leading && (digit_data == 4'd0) && (addr != 2'd0);
  end

  // Slot counter and digit address; scan runs 3 -> 2 -> 1 -> 0 and parks at 3 when disabled
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      slot_count <= '0;
      addr       <= 2'd3;
    end else if (!enable) begin
      slot_count <= '0;
      addr       <= 2'd3;
    end else begin
      slot_count <= slot_count_next;
      if (wrap) addr <= addr - 2'd1;
    end
  end

  // Leading flag: rearmed on entry to digit 3, survives only while zeros are being blanked
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      leading <= 1'b1;
    end else if (!enable) begin
      leading <= 1'b1;
    end else if (wrap && addr == 2'd0) begin
      leading <= 1'b1;
    end else if (latch && addr != 2'd0) begin
      leading <= suppress;
    end
  end

  // Segment/dp latched once per slot after the mux settles; digit drive dark during blanking
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      segment_out  <= SEG_OFF;
      dp_out       <= 1'b0;
      digit_enable <= '0;
    end else if (!enable) begin
      segment_out  <= SEG_OFF;
      dp_out       <= 1'b0;
      digit_enable <= '0;
    end else begin
      if (latch) begin
        segment_out <= suppress ? SEG_OFF : decoded;
        dp_out      <= dp_mask[addr];
      end
      digit_enable <= (int'(slot_count_next) >= BLANK_CYCLES) ? (4'b0001 << addr) : 4'b0000;
    end
  end

  assign mux_address = addr;

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - self-checking bench with a slot-level reference model
module tb_display_scan_controller;

  localparam int P = 16;
  localparam int B = 4;

  logic       clk_in = 1'b0;
  logic       reset_n_in;
  logic       enable;
  logic       blank_leading_zero;
  logic [3:0] dp_mask;
  logic [3:0] digit_data;
  logic [1:0] mux_address;
  logic [6:0] segment_out;
  logic       dp_out;
  logic [3:0] digit_enable;

  display_scan_controller #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk_in             (clk_in),
    .reset_n_in         (reset_n_in),
    .enable             (enable),
    .blank_leading_zero (blank_leading_zero),
    .dp_mask            (dp_mask),
    .digit_data         (digit_data),
    .mux_address        (mux_address),
    .segment_out        (segment_out),
    .dp_out             (dp_out),
    .digit_enable       (digit_enable)
  );

  always #5 clk_in = ~clk_in;

  // Upstream registered multiplexer: one cycle of latency
  logic [3:0] mem [4];
  always @(posedge clk_in) digit_data <= mem[mux_address];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: k = enabled edges since scanning (re)started
  int         k = 0;
  logic [6:0] exp_seg = 7'h00;
  logic       exp_dp = 1'b0;
  logic [3:0] lv [4];
  logic       lb [4];
  logic [6:0] seg_tab [16];

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
  end

  function automatic int cur_cnt();
    return k % P;
  endfunction

  function automatic int cur_digit();
    return 3 - ((k / P) % 4);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h (k=%0d)", tag, obs, expv, k);
    end
  endtask

  task automatic check_all();
    logic [3:0] de;
    de = (cur_cnt() >= B) ? (4'b0001 << cur_digit()) : 4'b0000;
    chk("digit_enable", {4'b0, digit_enable}, {4'b0, de});
    chk("mux_address", {6'b0, mux_address}, 8'(cur_digit()));
    chk("segment_out", {1'b0, segment_out}, {1'b0, exp_seg});
    chk("dp_out", {7'b0, dp_out}, {7'b0, exp_dp});
  endtask

  // Advance one clock: update the model from pre-edge inputs, then compare after the edge
  task automatic step();
    int  d;
    bit  blank;
    if (enable) begin
      if (cur_cnt() == B - 1) begin
        d = cur_digit();
        lv[d] = mem[d];
        lb[d] = blank_leading_zero;
        blank = (d != 0);
        for (int j = d; j < 4; j++) blank = blank && lb[j] && (lv[j] == 4'd0);
        exp_seg = blank ? 7'h00 : seg_tab[lv[d]];
        exp_dp  = dp_mask[d];
      end
      k++;
    end else begin
      k = 0;
      exp_seg = 7'h00;
      exp_dp  = 1'b0;
    end
    @(posedge clk_in);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until the model reaches a given digit/counter, bounded
  task automatic run_until(input int digit, input int cnt);
    int guard;
    guard = 0;
    while (!(cur_digit() == digit && cur_cnt() == cnt) && guard < 200) begin
      step();
      guard++;
    end
    vectors++;
    assert (guard < 200) else begin
      miscompares++;
      $error("FAIL run_until observed=timeout expected=digit%0d_cnt%0d", digit, cnt);
    end
  endtask

  task automatic load(input logic [3:0] d3, input logic [3:0] d2,
                      input logic [3:0] d1, input logic [3:0] d0);
    mem[3] = d3; mem[2] = d2; mem[1] = d1; mem[0] = d0;
  endtask

  initial begin
    reset_n_in = 1'b0;
    enable = 1'b0;
    blank_leading_zero = 1'b0;
    dp_mask = 4'b0000;
    load(4'd1, 4'd2, 4'd3, 4'd4);
    for (int i = 0; i < 4; i++) begin lv[i] = 4'd0; lb[i] = 1'b0; end
    repeat (3) @(posedge clk_in);
    #1;
    check_all();
    reset_n_in = 1'b1;
    run(2);

    // Basic scan: digits 1,2,3,4 on addresses 3,2,1,0
    enable = 1'b1;
    run(4 * P + 2);

    // Leading zeros suppressed, digit 0 still shown
    run_until(0, 8);
    blank_leading_zero = 1'b1;
    load(4'd0, 4'd0, 4'd0, 4'd0);
    run(4 * P + 4);

    // Interior zero after a non-zero digit stays visible
    run_until(0, 8);
    load(4'd0, 4'd5, 4'd0, 4'd7);
    run(4 * P + 4);

    // Invalid code and decimal point on digit 2
    run_until(0, 8);
    blank_leading_zero = 1'b0;
    dp_mask = 4'b0100;
    load(4'd1, 4'hC, 4'd3, 4'd4);
    run(4 * P + 4);

    // Randomized data, dp and suppression changes after each latch point
    for (int s = 0; s < 24; s++) begin
      run_until(int'($urandom_range(0, 3)), 8);
      mem[$urandom_range(0, 3)] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) mem[$urandom_range(0, 3)] = 4'd0;
      dp_mask = 4'($urandom);
      blank_leading_zero = 1'($urandom);
      run(int'($urandom_range(1, 20)));
    end

    // Enable drop at counter 8 of digit 1, then restart from digit 3
    run_until(1, 8);
    enable = 1'b0;
    run(3);
    enable = 1'b1;
    run(4 * P + 2);

    // Asynchronous reset in the middle of a slot
    run_until(2, 9);
    reset_n_in = 1'b0;
    #1;
    chk("rst_digit_enable", {4'b0, digit_enable}, 8'h00);
    chk("rst_segment_out", {1'b0, segment_out}, 8'h00);
    chk("rst_mux_address", {6'b0, mux_address}, 8'd3);
    chk("rst_dp_out", {7'b0, dp_out}, 8'h00);
    enable = 1'b0;
    k = 0;
    exp_seg = 7'h00;
    exp_dp = 1'b0;
    run(2);
    reset_n_in = 1'b1;
    run(1);
    enable = 1'b1;
    run(2 * P);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Time-multiplexed driver for the 4-digit 7-segment clock display.
- Generates the 2-bit digit address for the upstream registered 4-input 4-bit digit multiplexer.
- Consumes that multiplexer's 4-bit BCD output, decodes it to segments, and drives one-hot digit enables.
- Inserts a blanking gap between digits to prevent ghosting, and suppresses leading zeros when requested.

Parameters:
- PRESCALE, 4096: clock cycles per digit slot. Must be >= BLANK_CYCLES+2.
- BLANK_CYCLES, 64: cycles at the start of each slot with all digits off. Must be >= 2.

Ports:
- clk_in  input  1  system clock, single clock domain.
- reset_n_in  input  1  asynchronous, active-low reset.
- enable  input  1  1 = scanning; 0 = display dark and scan held.
- blank_leading_zero  input  1  1 = suppress leading zero digits 3..1.
- dp_mask  input  4  decimal point request per digit; bit i = digit i.
- digit_data  input  4  BCD value from the digit multiplexer; valid 1 cycle after mux_address changes.
- mux_address  output  2  digit select to the multiplexer.
- segment_out  output  7  active-high segments, bit order {g,f,e,d,c,b,a}.
- dp_out  output  1  active-high decimal point.
- digit_enable  output  4  active-high one-hot digit drive; bit i = digit i.

Behaviour:
- Reset (async, reset_n_in=0):
  - mux_address=2'd3, slot counter=0.
  - segment_out=0, dp_out=0, digit_enable=0.
  - leading flag=1.
- Slot counter runs 0..PRESCALE-1 while enable=1. Width is clog2(PRESCALE).
- On the edge where the counter wraps PRESCALE-1 -> 0, mux_address advances.
  - Scan order: 3 -> 2 -> 1 -> 0 -> 3.
  - On entry to digit 3, the leading flag is set to 1.
- Multiplexer latency is 1 cycle. digit_data is valid from counter==1 of each slot.
- Latch point: the edge ending counter==BLANK_CYCLES-1. segment_out and dp_out are registered there from digit_data and dp_mask[mux_address].
- Decode:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
  - Codes 10..15 give segments 7'h00.
- Leading-zero suppression, applied at the latch point for digits 3, 2 and 1:
  - If blank_leading_zero=1, the leading flag=1 and digit_data==0, then segment_out=0 and the flag stays 1.
  - Otherwise the flag clears.
  - Digit 0 is never suppressed.
  - dp_out is unaffected by suppression.
- digit_enable:
  - One-hot of mux_address while BLANK_CYCLES <= counter <= PRESCALE-1.
  - All zeros while counter < BLANK_CYCLES.
  - Registered; never more than one bit high.
- enable=0, sampled at the clock edge:
  - Next cycle: digit_enable=0, segment_out=0, dp_out=0, counter=0, mux_address=3, leading flag=1.
  - Held there while enable stays 0.
- enable 0 -> 1: scanning restarts at digit 3, counter 0. The first latch is at the end of counter BLANK_CYCLES-1.
- digit_data changing mid-slot: no effect until the next slot's latch point, so there is no flicker.
- dp_mask changing mid-slot: same rule as digit_data.
- Asynchronous reset mid-slot: all outputs go to reset values immediately.

Decomposition:
- Shared package display_pkg holds:
  - the segment encoding constants SEG_0..SEG_9 and SEG_OFF;
  - the digit count constant NUM_DIGITS=4;
  - the digit address type (2-bit).
- Sub-module bcd_to_7seg is purely combinational: 4-bit BCD in, 7-bit segments out. It is instantiated once and its output is registered in this block.

Test Plan (PRESCALE=16, BLANK_CYCLES=4):
- Reset, hold:
  - Stimulus: reset_n_in=0 asserted mid-slot.
  - Response: digit_enable=0, segment_out=0, mux_address=3 immediately, asynchronously.
- Basic scan:
  - Stimulus: enable=1, mux model returns digits 1,2,3,4 for addresses 3,2,1,0 with 1-cycle latency.
  - Response: digit_enable = 1000 (seg 06), then 0100 (5B), then 0010 (4F), then 0001 (66). Each is high for 12 cycles, preceded by 4 dark cycles; the period is 64 cycles.
- Leading zero, suppression on:
  - Stimulus: digits 0,0,0,0 with blank_leading_zero=1.
  - Response: digits 3..1 give segments 00 with their enable still asserted; digit 0 gives 3F.
- Leading zero, interior zero:
  - Stimulus: digits 0,5,0,7.
  - Response: digit 3 blank; digits 2/1/0 give 6D/3F/07.
- Invalid code and decimal point:
  - Stimulus: digit value 4'hC on address 2; dp_mask=0100.
  - Response: segment_out=00 and dp_out=1 during digit 2 only.
- Enable drop mid-slot:
  - Stimulus: enable=0 at counter 8 of digit 1.
  - Response: the next cycle has all outputs 0 and mux_address=3.
  - On re-enable, digit 3 is first; digit_enable=1000 after 4 cycles.
